// File: rtl/pc_fetch_unit.sv
// Fetch-stage program counter: drives the instruction-memory read and applies stalls.
// Also latches redirects that arrive during a stall and drains the pipe after a halt jump.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PC_Write,
  input  logic        jb_taken,
  input  logic [31:0] jb_target,
  input  logic        instr_waitrequest,
  output logic [31:0] instr_address,
  output logic        instr_read,
  output logic [31:0] IF_Reg_PC,
  output logic        Is_JB_stall,
  output logic        active
);

  localparam int unsigned    CNT_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {RUN, HALTING, HALTED} state_t;

  state_t           state, state_n;
  logic [31:0]      pc, pc_n;
  logic             pend_valid, pend_valid_n;
  logic [31:0]      pend_target, pend_target_n;
  logic [CNT_W-1:0] drain_cnt, drain_cnt_n;

  logic             adv;
  logic             eff_taken;
  logic [31:0]      eff_target;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      pc          <= RESET_VECTOR;
      pend_valid  <= 1'b0;
      pend_target <= '0;
      drain_cnt   <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      pend_valid  <= pend_valid_n;
      pend_target <= pend_target_n;
      drain_cnt   <= drain_cnt_n;
    end
  end

  // Next-state logic; a latched redirect outranks a fresh jb_taken.
  always_comb begin
    state_n       = state;
    pc_n          = pc;
    pend_valid_n  = pend_valid;
    pend_target_n = pend_target;
    drain_cnt_n   = drain_cnt;

    adv        = PC_Write & ~instr_waitrequest & (state == RUN);
    eff_taken  = pend_valid | jb_taken;
    eff_target = pend_valid ? pend_target : jb_target;

    case (state)
      RUN: begin
        if (adv) begin
          if (eff_taken && (eff_target == HALT_ADDR)) begin
            state_n      = HALTING;
            pend_valid_n = 1'b0;
            drain_cnt_n  = '0;
          end else if (eff_taken) begin
            pc_n         = {eff_target[31:2], 2'b00};
            pend_valid_n = 1'b0;
          end else begin
            pc_n = pc + 32'd4;
          end
        end else if (jb_taken && !pend_valid) begin
          pend_valid_n  = 1'b1;
          pend_target_n = jb_target;
        end
      end
      HALTING: begin
        drain_cnt_n = drain_cnt + CNT_W'(1);
        if (drain_cnt == DRAIN_LAST) state_n = HALTED;
      end
      HALTED:  state_n = HALTED;
      default: state_n = RUN;
    endcase
  end

  assign instr_address = pc;
  assign IF_Reg_PC     = pc;
  assign Is_JB_stall   = pend_valid;
  assign active        = (state != HALTED);
  // Gated by reset directly so the reset vector is read in the first cycle reset is low.
  assign instr_read    = (state == RUN) & ~reset;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: per-scenario stimulus rows, expected outputs
// queued on drive and popped after the clock edge that consumes them.
module tb_pc_fetch_unit;

  typedef struct packed {
    logic        rst;
    logic        pw;
    logic        wr;
    logic        jb;
    logic [31:0] tgt;
  } stim_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        rd;
    logic        act;
    logic        stl;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        PC_Write;
  logic        jb_taken;
  logic [31:0] jb_target;
  logic        instr_waitrequest;
  logic [31:0] instr_address;
  logic        instr_read;
  logic [31:0] IF_Reg_PC;
  logic        Is_JB_stall;
  logic        active;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sbq[$];

  pc_fetch_unit dut (
    .clk               (clk),
    .reset             (reset),
    .PC_Write          (PC_Write),
    .jb_taken          (jb_taken),
    .jb_target         (jb_target),
    .instr_waitrequest (instr_waitrequest),
    .instr_address     (instr_address),
    .instr_read        (instr_read),
    .IF_Reg_PC         (IF_Reg_PC),
    .Is_JB_stall       (Is_JB_stall),
    .active            (active)
  );

  always #5 clk = ~clk;

  function automatic stim_t r(logic rst, logic pw, logic wr, logic jb, logic [31:0] tgt);
    return {rst, pw, wr, jb, tgt};
  endfunction

  function automatic exp_t ex(logic [31:0] addr, logic rd, logic act, logic stl);
    return {addr, rd, act, stl};
  endfunction

  // Drive one row at the falling edge, queue its expectation, land on the next falling edge.
  task automatic apply(input stim_t s, input exp_t e);
    reset             = s.rst;
    PC_Write          = s.pw;
    instr_waitrequest = s.wr;
    jb_taken          = s.jb;
    jb_target         = s.tgt;
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    stim_t s[$];
    exp_t  e[$];
    exp_t  want;
    for (int i = 0; i < 3; i++) begin
      s.push_back(r(1, 1, 0, 1, 32'h0));
      e.push_back(ex(32'hBFC00000, 0, 1, 0));
    end
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i], e[i]);
      want = sbq.pop_front();
      n_checks++;
      if ({instr_address, instr_read, active, Is_JB_stall} !== want || IF_Reg_PC !== want.addr) begin
        n_fail++;
        $display("FAIL reset[%0d]: got addr=%h pc=%h rd=%b act=%b stl=%b, want addr=%h rd=%b act=%b stl=%b",
                 i, instr_address, IF_Reg_PC, instr_read, active, Is_JB_stall, want.addr, want.rd, want.act, want.stl);
      end
    end
    reset    = 1'b0;
    jb_taken = 1'b0;
    #1;
    n_checks++;
    if (instr_read !== 1'b1 || instr_address !== 32'hBFC00000 || active !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: got addr=%h rd=%b act=%b, want addr=bfc00000 rd=1 act=1",
               instr_address, instr_read, active);
    end
  endtask

  task automatic test_sequential();
    stim_t s[$];
    exp_t  e[$];
    exp_t  want;
    s.push_back(r(0, 1, 0, 0, 32'h0)); e.push_back(ex(32'hBFC00004, 1, 1, 0));
    s.push_back(r(0, 1, 0, 0, 32'h0)); e.push_back(ex(32'hBFC00008, 1, 1, 0));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i], e[i]);
      want = sbq.pop_front();
      n_checks++;
      if ({instr_address, instr_read, active, Is_JB_stall} !== want || IF_Reg_PC !== want.addr) begin
        n_fail++;
        $display("FAIL seq[%0d]: got addr=%h pc=%h rd=%b act=%b stl=%b, want addr=%h rd=%b act=%b stl=%b",
                 i, instr_address, IF_Reg_PC, instr_read, active, Is_JB_stall, want.addr, want.rd, want.act, want.stl);
      end
    end
  endtask

  task automatic test_redirect();
    stim_t s[$];
    exp_t  e[$];
    exp_t  want;
    s.push_back(r(0, 1, 0, 1, 32'h00400020)); e.push_back(ex(32'h00400020, 1, 1, 0));
    s.push_back(r(0, 1, 0, 0, 32'h0));        e.push_back(ex(32'h00400024, 1, 1, 0));
    s.push_back(r(0, 1, 0, 1, 32'h0040002B)); e.push_back(ex(32'h00400028, 1, 1, 0));
    s.push_back(r(0, 1, 0, 0, 32'h0));        e.push_back(ex(32'h0040002C, 1, 1, 0));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i], e[i]);
      want = sbq.pop_front();
      n_checks++;
      if ({instr_address, instr_read, active, Is_JB_stall} !== want || IF_Reg_PC !== want.addr) begin
        n_fail++;
        $display("FAIL redirect[%0d]: got addr=%h pc=%h rd=%b act=%b stl=%b, want addr=%h rd=%b act=%b stl=%b",
                 i, instr_address, IF_Reg_PC, instr_read, active, Is_JB_stall, want.addr, want.rd, want.act, want.stl);
      end
    end
  endtask

  task automatic test_stall_redirect();
    stim_t s[$];
    exp_t  e[$];
    exp_t  want;
    s.push_back(r(0, 1, 1, 1, 32'h00001000)); e.push_back(ex(32'h0040002C, 1, 1, 1));
    s.push_back(r(0, 1, 1, 1, 32'h00002000)); e.push_back(ex(32'h0040002C, 1, 1, 1));
    s.push_back(r(0, 1, 1, 0, 32'h0));        e.push_back(ex(32'h0040002C, 1, 1, 1));
    s.push_back(r(0, 1, 0, 1, 32'h00003000)); e.push_back(ex(32'h00001000, 1, 1, 0));
    s.push_back(r(0, 1, 0, 0, 32'h0));        e.push_back(ex(32'h00001004, 1, 1, 0));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i], e[i]);
      want = sbq.pop_front();
      n_checks++;
      if ({instr_address, instr_read, active, Is_JB_stall} !== want || IF_Reg_PC !== want.addr) begin
        n_fail++;
        $display("FAIL stall_redirect[%0d]: got addr=%h pc=%h rd=%b act=%b stl=%b, want addr=%h rd=%b act=%b stl=%b",
                 i, instr_address, IF_Reg_PC, instr_read, active, Is_JB_stall, want.addr, want.rd, want.act, want.stl);
      end
    end
  endtask

  task automatic test_pc_write_stall();
    stim_t s[$];
    exp_t  e[$];
    exp_t  want;
    s.push_back(r(0, 1, 0, 1, 32'hBFC00010)); e.push_back(ex(32'hBFC00010, 1, 1, 0));
    s.push_back(r(0, 0, 0, 0, 32'h0));        e.push_back(ex(32'hBFC00010, 1, 1, 0));
    s.push_back(r(0, 0, 0, 0, 32'h0));        e.push_back(ex(32'hBFC00010, 1, 1, 0));
    s.push_back(r(0, 1, 0, 0, 32'h0));        e.push_back(ex(32'hBFC00014, 1, 1, 0));
    s.push_back(r(0, 0, 1, 0, 32'h0));        e.push_back(ex(32'hBFC00014, 1, 1, 0));
    s.push_back(r(0, 1, 1, 0, 32'h0));        e.push_back(ex(32'hBFC00014, 1, 1, 0));
    s.push_back(r(0, 1, 0, 0, 32'h0));        e.push_back(ex(32'hBFC00018, 1, 1, 0));
    s.push_back(r(0, 0, 0, 1, 32'h00000100)); e.push_back(ex(32'hBFC00018, 1, 1, 1));
    s.push_back(r(0, 1, 0, 0, 32'h0));        e.push_back(ex(32'h00000100, 1, 1, 0));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i], e[i]);
      want = sbq.pop_front();
      n_checks++;
      if ({instr_address, instr_read, active, Is_JB_stall} !== want || IF_Reg_PC !== want.addr) begin
        n_fail++;
        $display("FAIL pc_write_stall[%0d]: got addr=%h pc=%h rd=%b act=%b stl=%b, want addr=%h rd=%b act=%b stl=%b",
                 i, instr_address, IF_Reg_PC, instr_read, active, Is_JB_stall, want.addr, want.rd, want.act, want.stl);
      end
    end
  endtask

  task automatic test_halt();
    stim_t s[$];
    exp_t  e[$];
    exp_t  want;
    s.push_back(r(0, 1, 0, 1, 32'hBFC00020)); e.push_back(ex(32'hBFC00020, 1, 1, 0));
    s.push_back(r(0, 1, 0, 1, 32'h0));        e.push_back(ex(32'hBFC00020, 0, 1, 0));
    s.push_back(r(0, 0, 1, 1, 32'h00001234)); e.push_back(ex(32'hBFC00020, 0, 1, 0));
    s.push_back(r(0, 1, 0, 1, 32'h00001234)); e.push_back(ex(32'hBFC00020, 0, 1, 0));
    s.push_back(r(0, 1, 0, 0, 32'h0));        e.push_back(ex(32'hBFC00020, 0, 0, 0));
    for (int i = 0; i < 10; i++) begin
      s.push_back(r(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom));
      e.push_back(ex(32'hBFC00020, 0, 0, 0));
    end
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i], e[i]);
      want = sbq.pop_front();
      n_checks++;
      if ({instr_address, instr_read, active, Is_JB_stall} !== want || IF_Reg_PC !== want.addr) begin
        n_fail++;
        $display("FAIL halt[%0d]: got addr=%h pc=%h rd=%b act=%b stl=%b, want addr=%h rd=%b act=%b stl=%b",
                 i, instr_address, IF_Reg_PC, instr_read, active, Is_JB_stall, want.addr, want.rd, want.act, want.stl);
      end
    end
  endtask

  task automatic test_reset_recovery();
    stim_t s[$];
    exp_t  e[$];
    exp_t  want;
    s.push_back(r(1, 1, 0, 0, 32'h0)); e.push_back(ex(32'hBFC00000, 0, 1, 0));
    s.push_back(r(0, 1, 0, 0, 32'h0)); e.push_back(ex(32'hBFC00004, 1, 1, 0));
    s.push_back(r(0, 1, 0, 1, 32'h0)); e.push_back(ex(32'hBFC00004, 0, 1, 0));
    s.push_back(r(0, 1, 0, 0, 32'h0)); e.push_back(ex(32'hBFC00004, 0, 1, 0));
    s.push_back(r(1, 1, 0, 0, 32'h0)); e.push_back(ex(32'hBFC00000, 0, 1, 0));
    s.push_back(r(0, 1, 0, 0, 32'h0)); e.push_back(ex(32'hBFC00004, 1, 1, 0));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i], e[i]);
      want = sbq.pop_front();
      n_checks++;
      if ({instr_address, instr_read, active, Is_JB_stall} !== want || IF_Reg_PC !== want.addr) begin
        n_fail++;
        $display("FAIL reset_recovery[%0d]: got addr=%h pc=%h rd=%b act=%b stl=%b, want addr=%h rd=%b act=%b stl=%b",
                 i, instr_address, IF_Reg_PC, instr_read, active, Is_JB_stall, want.addr, want.rd, want.act, want.stl);
      end
    end
  endtask

  task automatic test_wrap();
    stim_t s[$];
    exp_t  e[$];
    exp_t  want;
    s.push_back(r(0, 1, 0, 1, 32'hFFFFFFFC)); e.push_back(ex(32'hFFFFFFFC, 1, 1, 0));
    s.push_back(r(0, 1, 0, 0, 32'h0));        e.push_back(ex(32'h00000000, 1, 1, 0));
    s.push_back(r(0, 1, 0, 0, 32'h0));        e.push_back(ex(32'h00000004, 1, 1, 0));
    s.push_back(r(0, 1, 0, 0, 32'h0));        e.push_back(ex(32'h00000008, 1, 1, 0));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i], e[i]);
      want = sbq.pop_front();
      n_checks++;
      if ({instr_address, instr_read, active, Is_JB_stall} !== want || IF_Reg_PC !== want.addr) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got addr=%h pc=%h rd=%b act=%b stl=%b, want addr=%h rd=%b act=%b stl=%b",
                 i, instr_address, IF_Reg_PC, instr_read, active, Is_JB_stall, want.addr, want.rd, want.act, want.stl);
      end
    end
  endtask

  initial begin
    reset             = 1'b1;
    PC_Write          = 1'b1;
    instr_waitrequest = 1'b0;
    jb_taken          = 1'b0;
    jb_target         = 32'h0;
    test_reset();
    test_sequential();
    test_redirect();
    test_stall_redirect();
    test_pc_write_stall();
    test_halt();
    test_reset_recovery();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
